// File: rtl/piece_mover.sv
// rtl/piece_mover.sv - active piece movement, gravity, hard drop and lock on an 8x4 board
// Board bit index = row*4 + col; row 0 is the spawn row, row 7 the bottom row.
module piece_mover (
  input  logic        clka,
  input  logic        restart,
  input  logic        board_load,
  input  logic [31:0] board_new,
  input  logic [1:0]  piece_new,
  input  logic        error_in,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_drop,
  input  logic        tick,
  output logic [31:0] board_disp,
  output logic [31:0] board_to_clear,
  output logic        land_valid,
  output logic        game_over
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP, OVER} state_t;

  localparam logic [31:0] ROW7_CELLS = 32'hF000_0000;
  localparam logic [31:0] COL0_CELLS = 32'h1111_1111;
  localparam logic [31:0] COL3_CELLS = 32'h8888_8888;

  state_t      state, nxt_state;
  logic [31:0] static_cells, nxt_static;
  logic [31:0] mask, nxt_mask;
  logic [31:0] nxt_disp, nxt_clr;
  logic        nxt_lv, nxt_go;

  logic [31:0] spawn_mask;
  logic [31:0] down_mask, left_mask, right_mask;
  logic        down_ok, left_ok, right_ok;
  logic        take, lock;
  logic [31:0] cand;

  always_comb begin
    case (piece_new)
      2'b00:   spawn_mask = 32'h0000_0002;
      2'b01:   spawn_mask = 32'h0000_0006;
      2'b10:   spawn_mask = 32'h0000_0066;
      default: spawn_mask = 32'h0000_0062;
    endcase
  end

  assign down_mask  = mask << 4;
  assign left_mask  = mask >> 1;
  assign right_mask = mask << 1;
  assign down_ok    = ((mask & ROW7_CELLS) == 32'h0) && ((down_mask & static_cells) == 32'h0);
  assign left_ok    = ((mask & COL0_CELLS) == 32'h0) && ((left_mask & static_cells) == 32'h0);
  assign right_ok   = ((mask & COL3_CELLS) == 32'h0) && ((right_mask & static_cells) == 32'h0);

  always_comb begin
    nxt_state  = state;
    nxt_static = static_cells;
    nxt_mask   = mask;
    nxt_disp   = board_disp;
    nxt_clr    = board_to_clear;
    nxt_lv     = 1'b0;
    nxt_go     = game_over;
    take       = 1'b0;
    lock       = 1'b0;
    cand       = mask;
    case (state)
      IDLE: begin
        if (board_load) begin
          nxt_static = board_new & ~spawn_mask;
          nxt_mask   = spawn_mask;
          nxt_disp   = board_new;
          if (error_in) begin
            nxt_state = OVER;
            nxt_go    = 1'b1;
          end else begin
            nxt_state = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        if (btn_drop) begin
          nxt_state = DROP;
        end else if (tick) begin
          if (down_ok) begin
            take = 1'b1;
            cand = down_mask;
          end else begin
            lock = 1'b1;
          end
        end else if (btn_left) begin
          take = left_ok;
          cand = left_mask;
        end else if (btn_right) begin
          take = right_ok;
          cand = right_mask;
        end
      end
      DROP: begin
        if (down_ok) begin
          take = 1'b1;
          cand = down_mask;
        end else begin
          lock = 1'b1;
        end
      end
      default: ;
    endcase
    if (take) begin
      nxt_mask = cand;
      nxt_disp = static_cells | cand;
    end
    // Lock merges the piece into the static field; a same-cycle board_load is lost since we are not in IDLE.
    if (lock) begin
      nxt_static = static_cells | mask;
      nxt_clr    = static_cells | mask;
      nxt_disp   = static_cells | mask;
      nxt_mask   = 32'h0;
      nxt_lv     = 1'b1;
      nxt_state  = IDLE;
    end
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state          <= IDLE;
      static_cells   <= 32'h0;
      mask           <= 32'h0;
      board_disp     <= 32'h0;
      board_to_clear <= 32'h0;
      land_valid     <= 1'b0;
      game_over      <= 1'b0;
    end else begin
      state          <= nxt_state;
      static_cells   <= nxt_static;
      mask           <= nxt_mask;
      board_disp     <= nxt_disp;
      board_to_clear <= nxt_clr;
      land_valid     <= nxt_lv;
      game_over      <= nxt_go;
    end
  end

endmodule

// File: tb/tb_piece_mover.sv
// tb/tb_piece_mover.sv - scoreboard bench for piece_mover
module tb_piece_mover;

  logic        clka = 1'b0;
  logic        restart = 1'b1;
  logic        board_load = 1'b0;
  logic [31:0] board_new = 32'h0;
  logic [1:0]  piece_new = 2'b00;
  logic        error_in = 1'b0;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_drop = 1'b0, tick = 1'b0;
  logic [31:0] board_disp, board_to_clear;
  logic        land_valid, game_over;

  piece_mover dut (
    .clka(clka), .restart(restart), .board_load(board_load), .board_new(board_new),
    .piece_new(piece_new), .error_in(error_in), .btn_left(btn_left), .btn_right(btn_right),
    .btn_drop(btn_drop), .tick(tick), .board_disp(board_disp), .board_to_clear(board_to_clear),
    .land_valid(land_valid), .game_over(game_over)
  );

  always #5 clka = ~clka;

  typedef struct {
    string       name;
    logic [31:0] disp;
    logic [31:0] clr;
    logic        lv;
    logic        go;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   lands = 0;
  logic [31:0] clr_hold = 32'h0;
  event chk_now;

  always begin
    @(posedge clka or chk_now);
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      compared++;
      if (board_disp !== e.disp || board_to_clear !== e.clr || land_valid !== e.lv || game_over !== e.go) begin
        mismatched++;
        $display("FAIL %s: got disp=%h clr=%h lv=%b go=%b, want disp=%h clr=%h lv=%b go=%b",
                 e.name, board_disp, board_to_clear, land_valid, game_over, e.disp, e.clr, e.lv, e.go);
      end
    end
  end

  always @(posedge clka) begin
    #1;
    if (land_valid === 1'b1) lands++;
  end

  task automatic push(input string nm, input logic [31:0] d, input logic [31:0] c, input logic lv, input logic go);
    exp_t e;
    e.name = nm; e.disp = d; e.clr = c; e.lv = lv; e.go = go;
    sb.push_back(e);
  endtask

  // inp = {board_load, error_in, btn_left, btn_right, btn_drop, tick}
  task automatic step(input logic [5:0] inp, input logic [31:0] bn, input logic [1:0] pn,
                      input string nm, input logic [31:0] d, input logic lv, input logic go);
    @(negedge clka);
    {board_load, error_in, btn_left, btn_right, btn_drop, tick} = inp;
    board_new = bn;
    piece_new = pn;
    push(nm, d, clr_hold, lv, go);
    @(posedge clka);
  endtask

  localparam logic [5:0] NONE = 6'b000000, LOAD = 6'b100000, LOADE = 6'b110000;
  localparam logic [5:0] LEFT = 6'b001000, RIGHT = 6'b000100, DROPB = 6'b000010, TICK = 6'b000001;

  initial begin
    logic [31:0] d;
    #2;
    push("reset", 32'h0, 32'h0, 1'b0, 1'b0);
    ->chk_now;
    @(negedge clka);
    restart = 1'b0;

    step(LOAD, 32'h0000_0002, 2'b00, "grav_load", 32'h0000_0002, 1'b0, 1'b0);
    d = 32'h0000_0002;
    for (int k = 1; k <= 7; k++) begin
      d = d << 4;
      step(TICK, 32'h0, 2'b00, $sformatf("grav_tick%0d", k), d, 1'b0, 1'b0);
    end
    clr_hold = 32'h2000_0000;
    step(TICK, 32'h0, 2'b00, "grav_lock", 32'h2000_0000, 1'b1, 1'b0);
    step(NONE, 32'h0, 2'b00, "grav_after", 32'h2000_0000, 1'b0, 1'b0);

    step(LOAD, 32'h0000_0006, 2'b01, "wall_load", 32'h0000_0006, 1'b0, 1'b0);
    step(LEFT, 32'h0, 2'b00, "wall_left1", 32'h0000_0003, 1'b0, 1'b0);
    step(LEFT, 32'h0, 2'b00, "wall_left2", 32'h0000_0003, 1'b0, 1'b0);
    step(LOAD, 32'hFFFF_0000, 2'b11, "load_ignored_active", 32'h0000_0003, 1'b0, 1'b0);
    step(RIGHT, 32'h0, 2'b00, "wall_right1", 32'h0000_0006, 1'b0, 1'b0);
    step(RIGHT, 32'h0, 2'b00, "wall_right2", 32'h0000_000C, 1'b0, 1'b0);
    step(RIGHT, 32'h0, 2'b00, "wall_right3", 32'h0000_000C, 1'b0, 1'b0);
    d = 32'h0000_000C;
    for (int k = 1; k <= 7; k++) begin
      d = d << 4;
      step(TICK, 32'h0, 2'b00, $sformatf("wall_tick%0d", k), d, 1'b0, 1'b0);
    end
    clr_hold = 32'hC000_0000;
    step(TICK, 32'h0, 2'b00, "wall_lock", 32'hC000_0000, 1'b1, 1'b0);

    step(LOAD, 32'hF000_0066, 2'b10, "drop_load", 32'hF000_0066, 1'b0, 1'b0);
    step(DROPB, 32'h0, 2'b00, "drop_enter", 32'hF000_0066, 1'b0, 1'b0);
    step(LEFT, 32'h0, 2'b00, "drop_mv1", 32'hF000_0660, 1'b0, 1'b0);
    step(RIGHT, 32'h0, 2'b00, "drop_mv2", 32'hF000_6600, 1'b0, 1'b0);
    step(NONE, 32'h0, 2'b00, "drop_mv3", 32'hF006_6000, 1'b0, 1'b0);
    step(TICK, 32'h0, 2'b00, "drop_mv4", 32'hF066_0000, 1'b0, 1'b0);
    step(NONE, 32'h0, 2'b00, "drop_mv5", 32'hF660_0000, 1'b0, 1'b0);
    clr_hold = 32'hF660_0000;
    step(LOAD, 32'h0000_0001, 2'b00, "drop_lock", 32'hF660_0000, 1'b1, 1'b0);
    step(NONE, 32'h0, 2'b00, "load_at_lock_ignored", 32'hF660_0000, 1'b0, 1'b0);

    step(LOAD, 32'h0000_0002, 2'b00, "prio_load", 32'h0000_0002, 1'b0, 1'b0);
    step(LEFT | TICK, 32'h0, 2'b00, "prio_tick_over_left", 32'h0000_0020, 1'b0, 1'b0);
    step(LEFT | RIGHT, 32'h0, 2'b00, "prio_left_over_right", 32'h0000_0010, 1'b0, 1'b0);
    step(DROPB | TICK, 32'h0, 2'b00, "prio_drop_over_tick", 32'h0000_0010, 1'b0, 1'b0);
    d = 32'h0000_0010;
    for (int k = 2; k <= 7; k++) begin
      d = d << 4;
      step(NONE, 32'h0, 2'b00, $sformatf("prio_drop_row%0d", k), d, 1'b0, 1'b0);
    end
    clr_hold = 32'h1000_0000;
    step(NONE, 32'h0, 2'b00, "prio_lock", 32'h1000_0000, 1'b1, 1'b0);

    step(LOAD, 32'h0000_0002, 2'b00, "rst_load", 32'h0000_0002, 1'b0, 1'b0);
    step(DROPB, 32'h0, 2'b00, "rst_drop", 32'h0000_0002, 1'b0, 1'b0);
    step(NONE, 32'h0, 2'b00, "rst_mv1", 32'h0000_0020, 1'b0, 1'b0);
    @(negedge clka);
    {board_load, error_in, btn_left, btn_right, btn_drop, tick} = NONE;
    #2;
    restart = 1'b1;
    clr_hold = 32'h0;
    push("rst_async", 32'h0, 32'h0, 1'b0, 1'b0);
    ->chk_now;
    @(posedge clka);
    @(negedge clka);
    restart = 1'b0;
    for (int k = 0; k < 4; k++)
      step(NONE, 32'h0, 2'b00, $sformatf("rst_quiet%0d", k), 32'h0, 1'b0, 1'b0);

    step(LOADE, 32'h0000_0006, 2'b01, "over_enter", 32'h0000_0006, 1'b0, 1'b1);
    step(LOAD, 32'h0000_00FF, 2'b00, "over_load", 32'h0000_0006, 1'b0, 1'b1);
    step(TICK, 32'h0, 2'b00, "over_tick", 32'h0000_0006, 1'b0, 1'b1);
    step(LEFT, 32'h0, 2'b00, "over_left", 32'h0000_0006, 1'b0, 1'b1);
    step(DROPB, 32'h0, 2'b00, "over_drop", 32'h0000_0006, 1'b0, 1'b1);
    @(negedge clka);
    {board_load, error_in, btn_left, btn_right, btn_drop, tick} = NONE;
    #2;
    restart = 1'b1;
    push("over_restart", 32'h0, 32'h0, 1'b0, 1'b0);
    ->chk_now;
    @(negedge clka);
    restart = 1'b0;
    step(LOAD, 32'h0000_0062, 2'b11, "after_restart_load", 32'h0000_0062, 1'b0, 1'b0);
    step(RIGHT, 32'h0, 2'b00, "after_restart_right", 32'h0000_00C4, 1'b0, 1'b0);

    repeat (3) @(posedge clka);
    #2;
    compared++;
    if (lands != 4) begin
      mismatched++;
      $display("FAIL land_count: got %0d, want 4", lands);
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/piece_mover.md
PIECE_MOVER -- requirements
Module: piece_mover

Interface
REQ-001 The block SHALL have no parameters; the board is fixed at 8 rows x 4 columns, bit index = row*4 + col, row 0 (bits 3:0) is the top/spawn row, and row 7 (bits 31:28) is the bottom row.
REQ-002 clka  input  1  single clock; all state updates on the rising edge.
REQ-003 restart  input  1  asynchronous, active-high reset.
REQ-004 board_load  input  1  one-cycle pulse: board_new/piece_new/error_in valid (from clear_redraw output side).
REQ-005 board_new  input  32  cleared board including freshly spawned piece cells.
REQ-006 piece_new  input  2  spawned piece type (00 single, 01 pair, 10 square, 11 L).
REQ-007 error_in  input  1  spawn collision flag accompanying board_load.
REQ-008 btn_left, btn_right, btn_drop  input  1 each  single-cycle move requests.
REQ-009 tick  input  1  gravity enable, one-row fall request.
REQ-010 board_disp  output  32  registered static cells OR active piece mask.
REQ-011 board_to_clear  output  32  registered merged board at lock, held until next lock.
REQ-012 land_valid  output  1  one-cycle pulse qualifying board_to_clear.
REQ-013 game_over  output  1  sticky spawn-failure flag.

Function
REQ-014 Spawn masks SHALL be: 00 -> bit 1; 01 -> bits 1,2; 10 -> bits 1,2,5,6; 11 -> bits 1,5,6.
REQ-015 On accepted board_load, static SHALL = board_new AND NOT mask, mask = spawn mask of piece_new.
REQ-016 States SHALL be IDLE, ACTIVE, DROP and OVER.
REQ-017 In IDLE, a board_load with error_in=0 SHALL go to ACTIVE, with board_disp = board_new after the same edge.
REQ-018 In IDLE, a board_load with error_in=1 SHALL go to OVER, with game_over=1 and board_disp = board_new after that edge.
REQ-019 board_load outside IDLE SHALL be ignored.
REQ-020 In ACTIVE, at most one move SHALL be taken per cycle, priority btn_drop > tick > btn_left > btn_right.
REQ-021 btn_drop in ACTIVE SHALL enter DROP without moving that cycle.
REQ-022 Down move legality: mask has no bit in row 7, and (mask << 4) AND static == 0.
REQ-023 Left move is col-1 (right shift by 1): legal only if mask has no col-0 bit and the shifted mask does not collide with static.
REQ-024 Right move is col+1 (left shift by 1): legal only if mask has no col-3 bit and no collision.
REQ-025 An illegal left/right move SHALL be a no-op; the state SHALL stay ACTIVE.
REQ-026 A legal move SHALL update mask and board_disp at the same edge (1-cycle latency).
REQ-027 In DROP, the piece SHALL attempt one down move per cycle; buttons and tick are ignored.
REQ-028 A blocked down attempt (tick in ACTIVE, or any cycle in DROP) SHALL lock at that edge:
- board_to_clear = static OR mask, land_valid = 1 for exactly one cycle;
- static = static OR mask, mask = 0;
- state -> IDLE.
REQ-029 OVER SHALL hold all outputs, with land_valid=0, until restart.
REQ-030 A board_load arriving in the same cycle as a lock SHALL be ignored, because the block is not in IDLE.

Reset
REQ-031 restart SHALL asynchronously force state IDLE and clear static, mask, board_disp, board_to_clear, land_valid and game_over to 0, including mid-ACTIVE or mid-DROP.
REQ-032 After restart deasserts, the first accepted board_load SHALL behave exactly as from power-up.

Verification
REQ-033 Gravity: load 0x00000002 with piece 00, then 7 ticks -> board_disp 0x20000000; 8th tick -> land_valid pulse, board_to_clear 0x20000000, state IDLE.
REQ-034 Wall: load 0x00000006 with piece 01; btn_left -> 0x00000003; btn_left again -> 0x00000003 unchanged; btn_right x3 -> 0x00000006, then 0x0000000C, then 0x0000000C.
REQ-035 Hard drop: load 0xF0000066 with piece 10, then btn_drop -> 5 down cycles reaching board_disp 0xF6600000; next cycle land_valid=1, board_to_clear 0xF6600000.
REQ-036 Priority: btn_left and tick together in ACTIVE on 0x00000002 -> board_disp 0x00000020 (down only).
REQ-037 Game over: board_load with error_in=1 -> game_over=1; further board_load, tick and buttons -> no change; restart -> all outputs 0.
REQ-038 Reset mid-DROP: assert restart asynchronously between edges -> outputs 0 immediately; no land_valid pulse afterwards.
